// File: rtl/id_ex_stage_buf.sv
// Elastic ID/EX stage register: valid/ready handshake, optional 2-entry skid,
// flush/kill handling and a saturating bubble counter.
module id_ex_stage_buf #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 224,
    parameter int KEEP_W = 96,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_killed,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic              killed;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    beat_t beat;
    beat_t m_q;
    logic  acc;
    logic  deq;
    logic  s_valid;
    logic  bump;

    assign acc = in_valid & in_ready;
    assign deq = m_q.valid & out_ready;

    // A killed beat keeps only its PC fields so execute can still redirect.
    always_comb begin
        beat        = '0;
        beat.valid  = 1'b1;
        beat.killed = kill;
        beat.keep   = in_keep;
        if (!kill) begin
            beat.ctrl = in_ctrl;
            beat.data = in_data;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            beat_t s_q;

            assign in_ready = !s_q.valid;
            assign s_valid  = s_q.valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_q <= '0;
                    s_q <= '0;
                end else if (flush) begin
                    m_q <= '0;
                    s_q <= '0;
                end else if (!m_q.valid || deq) begin
                    if (s_q.valid) begin
                        m_q <= s_q;
                        s_q <= acc ? beat : beat_t'('0);
                    end else if (acc) begin
                        m_q <= beat;
                    end else begin
                        m_q.valid <= 1'b0;
                    end
                end else if (acc) begin
                    s_q <= beat;
                end
            end
        end else begin : g_reg
            assign in_ready = !m_q.valid || out_ready;
            assign s_valid  = 1'b0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_q <= '0;
                end else if (flush) begin
                    m_q <= '0;
                end else if (acc) begin
                    m_q <= beat;
                end else if (deq) begin
                    m_q.valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Flush counts once per cycle that actually discarded something.
    assign bump = flush ? (m_q.valid | s_valid | acc) : (acc & kill);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_cnt <= '0;
        else if (bump && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

    assign out_valid  = m_q.valid;
    assign out_ctrl   = m_q.ctrl;
    assign out_data   = m_q.data;
    assign out_keep   = m_q.keep;
    assign out_killed = m_q.killed;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: skid instance and a single-register CNT_W=2
// instance, both checked against a queue-based reference model.
module tb_id_ex_stage_buf;

    localparam int CW = 20;
    localparam int DW = 224;
    localparam int KW = 96;
    localparam logic [KW-1:0] KILL_KEEP = 96'h00400010_00400014_00400100;

    typedef struct packed {
        logic          killed;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } mb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, kill = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;

    logic          in_ready_a, out_valid_a, out_killed_a;
    logic [CW-1:0] out_ctrl_a;
    logic [DW-1:0] out_data_a;
    logic [KW-1:0] out_keep_a;
    logic [15:0]   bubble_cnt_a;

    logic          in_ready_b, out_valid_b, out_killed_b;
    logic [CW-1:0] out_ctrl_b;
    logic [DW-1:0] out_data_b;
    logic [KW-1:0] out_keep_b;
    logic [1:0]    bubble_cnt_b;

    int checks = 0;
    int errors = 0;

    mb_t qa[$];
    mb_t qb[$];
    int  ca, cb;
    bit  za, zb;

    always #5 clk = ~clk;

    id_ex_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .KEEP_W(KW), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_keep(in_keep), .kill(kill), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
        .out_data(out_data_a), .out_keep(out_keep_a), .out_killed(out_killed_a),
        .bubble_cnt(bubble_cnt_a)
    );

    id_ex_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .KEEP_W(KW), .SKID(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_keep(in_keep), .kill(kill), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
        .out_data(out_data_b), .out_keep(out_keep_b), .out_killed(out_killed_b),
        .bubble_cnt(bubble_cnt_b)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic compare_one(input string p, input logic v, input logic r, input logic kd,
                               input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic [KW-1:0] k, input int cnt, input mb_t q[$],
                               input bit z, input bit exp_r, input int exp_cnt);
        check({p, "_valid"}, v, q.size() > 0);
        if (q.size() > 0) begin
            check({p, "_ctrl"}, c, q[0].ctrl);
            check({p, "_data"}, d, q[0].data);
            check({p, "_keep"}, k, q[0].keep);
            check({p, "_killed"}, kd, q[0].killed);
        end else if (z) begin
            check({p, "_ctrl0"}, c, 0);
            check({p, "_data0"}, d, 0);
            check({p, "_keep0"}, k, 0);
            check({p, "_killed0"}, kd, 0);
        end
        check({p, "_ready"}, r, exp_r);
        check({p, "_cnt"}, cnt, exp_cnt);
    endtask

    function automatic bit rdy_a();
        return qa.size() < 2;
    endfunction

    function automatic bit rdy_b();
        return qb.size() == 0 || out_ready;
    endfunction

    task automatic compare();
        compare_one("a", out_valid_a, in_ready_a, out_killed_a, out_ctrl_a, out_data_a,
                    out_keep_a, int'(bubble_cnt_a), qa, za, rdy_a(), ca);
        compare_one("b", out_valid_b, in_ready_b, out_killed_b, out_ctrl_b, out_data_b,
                    out_keep_b, int'(bubble_cnt_b), qb, zb, rdy_b(), cb);
    endtask

    // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (plain register).
    task automatic model_step();
        mb_t nb;
        bit  acc_a, acc_b;
        nb.killed = kill;
        nb.keep   = in_keep;
        nb.ctrl   = kill ? '0 : in_ctrl;
        nb.data   = kill ? '0 : in_data;
        acc_a = in_valid && rdy_a();
        acc_b = in_valid && rdy_b();
        if (flush) begin
            if ((qa.size() > 0 || acc_a) && ca < 65535) ca++;
            if ((qb.size() > 0 || acc_b) && cb < 3) cb++;
            qa.delete();
            qb.delete();
            za = 1;
            zb = 1;
        end else begin
            if (qa.size() > 0 && out_ready) void'(qa.pop_front());
            if (qb.size() > 0 && out_ready) void'(qb.pop_front());
            if (acc_a) begin
                qa.push_back(nb);
                za = 0;
                if (kill && ca < 65535) ca++;
            end
            if (acc_b) begin
                qb.push_back(nb);
                zb = 0;
                if (kill && cb < 3) cb++;
            end
        end
    endtask

    task automatic drive(input bit v, input bit k, input bit f, input bit r);
        in_valid  = v;
        kill      = k;
        flush     = f;
        out_ready = r;
        #1;
        compare();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 0;
        kill     = 0;
        flush    = 0;
        reset    = 1;
        #1;
        qa.delete();
        qb.delete();
        ca = 0;
        cb = 0;
        za = 1;
        zb = 1;
        compare();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Streaming with out_ready high.
        in_ctrl = 20'h12345;
        in_data = DW'(rnd());
        in_keep = KW'(rnd());
        repeat (4) drive(1, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 1);

        // Kill beat: PC fields survive, payload zeroed.
        in_keep = KILL_KEEP;
        drive(1, 1, 0, 1);
        check("kill_keep", out_keep_a, KILL_KEEP);
        check("kill_ctrl", out_ctrl_a, 0);
        check("kill_data", out_data_a, 0);
        check("kill_flag", out_killed_a, 1);
        check("kill_cnt", bubble_cnt_a, 1);
        drive(0, 0, 0, 1);

        // Back-pressure: A in M, B in S, C refused, then drain in order.
        for (int i = 0; i < 3; i++) begin
            in_ctrl = CW'($urandom);
            in_data = DW'(rnd());
            in_keep = KW'(rnd());
            drive(1, 0, 0, 0);
        end
        check("stall_ready", in_ready_a, 0);
        repeat (2) drive(1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1);

        // Flush with both entries full and a beat offered, then flush while empty.
        repeat (2) begin
            in_data = DW'(rnd());
            drive(1, 0, 0, 0);
        end
        drive(1, 0, 1, 0);
        check("flush_valid", out_valid_a, 0);
        check("flush_ready", in_ready_a, 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);

        // Counter saturation on the CNT_W=2 instance.
        do_reset();
        repeat (5) drive(1, 1, 0, 1);
        check("sat_b", bubble_cnt_b, 3);
        drive(0, 0, 0, 1);

        // Asynchronous reset mid-stall with both entries full.
        repeat (3) begin
            in_ctrl = CW'($urandom);
            drive(1, 0, 0, 0);
        end
        #2;
        reset = 1;
        #1;
        check("areset_valid", out_valid_a, 0);
        check("areset_ctrl", out_ctrl_a, 0);
        check("areset_ready", in_ready_a, 1);
        @(negedge clk);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            in_ctrl = CW'($urandom);
            in_data = DW'(rnd());
            in_keep = KW'(rnd());
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
